// File: rtl/chan_counter_pkg.sv
// Shared definitions for the channel counter bank: mode encodings and the
// helper that sizes the channel-index port.
package chan_counter_pkg;

   typedef enum logic {
      MODE_STOP = 1'b0,
      MODE_WRAP = 1'b1
   } mode_e;

   // Width of a channel index: ceil(log2(n)), never less than one bit.
   function automatic int ch_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/chan_counter_cell.sv
// One counter channel: count register, terminal compare against the shared
// terminal value, and the registered terminal indication (level in stop
// mode, single-cycle pulse on each wrap in wrap mode).
module chan_counter_cell
   import chan_counter_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up_i,
   input  logic             clear_i,
   input  logic             mode_i,
   input  logic [CNT_W-1:0] term_val_i,
   output logic [CNT_W-1:0] count_o,
   output logic             over_o
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             over_q, over_d;
   logic             term;

   // Next-state: clear wins over up; stop mode holds at terminal, wrap mode
   // returns to zero. The stop-mode indication follows the current count so
   // it rises the cycle after the count reaches the terminal value.
   always_comb begin
      term    = (count_q >= term_val_i);
      count_d = count_q;
      over_d  = 1'b0;
      if (clear_i) begin
         count_d = '0;
         over_d  = 1'b0;
      end else if (mode_i == MODE_WRAP) begin
         if (up_i) begin
            count_d = term ? '0 : count_q + CNT_W'(1);
         end
         over_d = up_i & term;
      end else begin
         if (up_i && !term) begin
            count_d = count_q + CNT_W'(1);
         end
         over_d = term;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         over_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         over_q  <= over_d;
      end
   end

   assign count_o = count_q;
   assign over_o  = over_q;

endmodule

// File: rtl/chan_counter_bank.sv
// Bank of NUM_CH independent up-counters sharing a terminal value and mode,
// with a one-cycle-latency registered read port.
// Optional feature macro: CHAN_COUNTER_SNAPSHOT_EN adds a snap input and a
// per-channel shadow copy of {count_over, count}; reads then return shadows.
module chan_counter_bank
   import chan_counter_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int CNT_W  = 16,
   localparam int CH_W   = ch_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] up,
   input  logic [NUM_CH-1:0] clear,
   input  logic [CNT_W-1:0]  term_val,
   input  logic              mode,
`ifdef CHAN_COUNTER_SNAPSHOT_EN
   input  logic              snap,
`endif
   output logic [NUM_CH-1:0] count_over,
   input  logic              rd_req,
   input  logic [CH_W-1:0]   rd_ch,
   output logic              rd_ack,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_over
);

   logic [CNT_W-1:0] count_w [NUM_CH];
   logic [CNT_W-1:0] src_cnt [NUM_CH];
   logic [NUM_CH-1:0] src_over;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
         chan_counter_cell #(
            .CNT_W (CNT_W)
         ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .up_i       (up[gi]),
            .clear_i    (clear[gi]),
            .mode_i     (mode),
            .term_val_i (term_val),
            .count_o    (count_w[gi]),
            .over_o     (count_over[gi])
         );
`ifdef CHAN_COUNTER_SNAPSHOT_EN
         logic [CNT_W:0] shadow_q;
         // Shadow captures the channel's current state whenever snap is high.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               shadow_q <= '0;
            end else if (snap) begin
               shadow_q <= {count_over[gi], count_w[gi]};
            end
         end
         assign src_cnt[gi]  = shadow_q[CNT_W-1:0];
         assign src_over[gi] = shadow_q[CNT_W];
`else
         assign src_cnt[gi]  = count_w[gi];
         assign src_over[gi] = count_over[gi];
`endif
      end
   endgenerate

   logic [CNT_W-1:0] rd_data_d, rd_data_q;
   logic             rd_over_d, rd_over_q;
   logic             rd_ack_q;

   // Read mux: an index beyond the last channel selects nothing and reads 0.
   always_comb begin
      rd_data_d = '0;
      rd_over_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_req && (int'(rd_ch) == i)) begin
            rd_data_d = src_cnt[i];
            rd_over_d = src_over[i];
         end
      end
   end

   // Read response registers; data is forced to zero whenever no ack follows.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ack_q  <= 1'b0;
         rd_data_q <= '0;
         rd_over_q <= 1'b0;
      end else begin
         rd_ack_q  <= rd_req;
         rd_data_q <= rd_data_d;
         rd_over_q <= rd_over_d;
      end
   end

   assign rd_ack  = rd_ack_q;
   assign rd_data = rd_data_q;
   assign rd_over = rd_over_q;

endmodule
